text_fetch_ctrl: RTL and testbench

Sequences the 80x40 text-mode pixel pipeline: for every 8-pixel character cell it reads the character code from text RAM, then the 8x12 glyph from font ROM, selects the current glyph line, and shifts it out as a 1-bit pixel stream. It also applies a per-cell inverse attribute and a blinking underline cursor. It sits between the VGA sync counters and `pix_to_rgb`, and drives the shared text RAM read port and font ROM address.

---
 rtl/text_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_text_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_fetch_ctrl.sv
// Text-mode fetch controller: for each 8-pixel cell it fetches the character
// from text RAM and the glyph from font ROM. It selects the current glyph
// line, applies the inverse and cursor attributes, and serialises the line
// into a registered 1-bit pixel stream.
module text_fetch_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int COLS      = 80,
    parameter int ROWS      = 40,
    parameter int BLINK_BIT = 5
) (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic [9:0]  HorizontalCounter,
    input  logic [9:0]  VerticalCounter,
    output logic [11:0] text_addr,
    output logic        text_rd,
    input  logic [7:0]  text_data,
    output logic [6:0]  font_addr,
    input  logic [95:0] font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    output logic        Pixel,
    output logic        pixel_valid
);

    localparam logic [9:0]  H_ACT_W   = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_NEXT_LN = 10'(H_TOTAL - 8);
    localparam logic [9:0]  H_LAST_TR = 10'(H_ACTIVE - 8);
    localparam logic [9:0]  V_ACT_W   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  GLYPH_H   = 10'd12;
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [5:0]  ROWS_W    = 6'(ROWS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TXT_REQ,
        ST_TXT_WAIT,
        ST_FONT_REQ,
        ST_FONT_WAIT,
        ST_CAPTURE
    } state_e;

    state_e      state_q;
    logic [11:0] text_addr_q;
    logic        text_rd_q;
    logic [6:0]  font_addr_q;
    logic        inv_q;
    logic [6:0]  fetch_col_q;
    logic [5:0]  fetch_row_q;
    logic [3:0]  fetch_line_q;
    logic [7:0]  staging_q;
    logic [7:0]  shifter_q;
    logic        pixel_q;
    logic        pixel_valid_q;
    logic [5:0]  frame_cnt_q;
    logic [5:0]  row_q;
    logic [3:0]  line_q;
    logic        sync_q;

    logic [9:0]  h;
    logic [9:0]  v;
    logic [9:0]  v_next;
    logic [5:0]  v_next_row;
    logic [3:0]  v_next_line;
    logic        cell_start;
    logic        visible;
    logic        trig_line;
    logic        trig_next;
    logic [6:0]  trig_col;
    logic [5:0]  trig_row;
    logic [3:0]  trig_line_idx;
    logic [11:0] trig_addr;
    logic [7:0]  glyph_row;
    logic        cursor_hit;

    assign h = HorizontalCounter;
    assign v = VerticalCounter;

    // Decode the sync counters into fetch triggers and the cell being fetched.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        v_next        = (v == V_LAST) ? 10'd0 : v + 10'd1;
        v_next_row    = 6'(v_next / GLYPH_H);
        v_next_line   = 4'(v_next % GLYPH_H);
        cell_start    = (h[2:0] == 3'd0);
        visible       = (h < H_ACT_W) && (v < V_ACT_W);
        // In-line fetches need row/line counters that have resynced since reset.
        trig_line     = sync_q && cell_start && (h < H_LAST_TR) && (v < V_ACT_W)
                        && (row_q < ROWS_W);
        trig_next     = (h == H_NEXT_LN) && (v_next < V_ACT_W);
        trig_col      = h[9:3] + 7'd1;
        trig_row      = row_q;
        trig_line_idx = line_q;
        if (trig_next) begin
            trig_col      = 7'd0;
            trig_row      = v_next_row;
            trig_line_idx = v_next_line;
        end
        trig_addr = 12'(trig_row) * COLS_W + 12'(trig_col);
    end

    // Select the glyph line for the cell in flight and evaluate the cursor.
    always_comb begin
        glyph_row  = 8'(font_data >> {(4'd11 - fetch_line_q), 3'b000});
        cursor_hit = cursor_en && (fetch_col_q == cursor_col) && (fetch_row_q == cursor_row)
                     && (fetch_line_q >= 4'd10) && frame_cnt_q[BLINK_BIT];
    end

    // Cell row and glyph line track the line being displayed, resampled every line end.
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            row_q  <= '0;
            line_q <= '0;
            sync_q <= 1'b0;
        end else if (h == H_LAST) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            row_q  <= v_next_row;
            line_q <= v_next_line;
            sync_q <= 1'b1;
        end
    end

    // Frame counter for cursor blink, stepped once per frame at the start of vertical blank.
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if ((h == 10'd0) && (v == V_ACT_W)) begin
            frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    // Fetch FSM: text RAM read, font ROM read, glyph line capture into staging.
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            text_addr_q  <= '0;
            text_rd_q    <= 1'b0;
            font_addr_q  <= '0;
            inv_q        <= 1'b0;
            fetch_col_q  <= '0;
            fetch_row_q  <= '0;
            fetch_line_q <= '0;
            staging_q    <= '0;
        end else begin
            // Staging is consumed by the shifter load; clearing it means a missed fetch shows blank.
            if (visible && cell_start) begin
                staging_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trig_line || trig_next) begin
                        text_addr_q  <= trig_addr;
                        text_rd_q    <= 1'b1;
                        fetch_col_q  <= trig_col;
                        fetch_row_q  <= trig_row;
                        fetch_line_q <= trig_line_idx;
                        state_q      <= ST_TXT_REQ;
                    end
                end
                ST_TXT_REQ: begin
                    text_rd_q <= 1'b0;
                    state_q   <= ST_TXT_WAIT;
                end
                ST_TXT_WAIT: begin
                    font_addr_q <= text_data[6:0];
                    inv_q       <= text_data[7];
                    state_q     <= ST_FONT_REQ;
                end
                ST_FONT_REQ: begin
                    state_q <= ST_FONT_WAIT;
                end
                ST_FONT_WAIT: begin
                    staging_q <= glyph_row ^ {8{inv_q ^ cursor_hit}};
                    state_q   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel shifter: load at each cell start, shift left otherwise, cleared outside the visible area.
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            shifter_q     <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else if (visible) begin
            pixel_valid_q <= 1'b1;
            if (cell_start) begin
                shifter_q <= staging_q;
                pixel_q   <= staging_q[7];
            end else begin
                shifter_q <= {shifter_q[6:0], 1'b0};
                pixel_q   <= shifter_q[6];
            end
        end else begin
            shifter_q     <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
        end
    end

    assign text_addr   = text_addr_q;
    assign text_rd     = text_rd_q;
    assign font_addr   = font_addr_q;
    assign Pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Directed bench for text_fetch_ctrl: drives the sync counters directly,
// models a synchronous text RAM and font ROM, and captures one line of
// pixels at a time for comparison against hand-computed glyph bytes.
module tb_text_fetch_ctrl;

    logic        clock25;
    logic        reset_n;
    logic [9:0]  HorizontalCounter;
    logic [9:0]  VerticalCounter;
    logic [11:0] text_addr;
    logic        text_rd;
    logic [7:0]  text_data;
    logic [6:0]  font_addr;
    logic [95:0] font_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        Pixel;
    logic        pixel_valid;

    int checks;
    int errors;
    int rd_count;
    logic [11:0] last_addr;
    logic pix [0:799];
    logic pv  [0:799];
    logic [7:0] ram [0:4095];

    text_fetch_ctrl dut (
        .clock25          (clock25),
        .reset_n          (reset_n),
        .HorizontalCounter(HorizontalCounter),
        .VerticalCounter  (VerticalCounter),
        .text_addr        (text_addr),
        .text_rd          (text_rd),
        .text_data        (text_data),
        .font_addr        (font_addr),
        .font_data        (font_data),
        .cursor_en        (cursor_en),
        .cursor_col       (cursor_col),
        .cursor_row       (cursor_row),
        .Pixel            (Pixel),
        .pixel_valid      (pixel_valid)
    );

    initial clock25 = 1'b0;
    always #20 clock25 = ~clock25;

    // Glyph content: 'A' is hand-drawn, every other code gets a distinct byte per line.
    function automatic logic [7:0] glyph_line(input logic [6:0] code, input int r);
        if (code == 7'h41) begin
            case (r)
                0: return 8'h18;  1: return 8'h3C;  2: return 8'h66;  3: return 8'h66;
                4: return 8'h7E;  5: return 8'h66;  6: return 8'h66;  7: return 8'h66;
                8: return 8'h66;  9: return 8'h3C; 10: return 8'h81; 11: return 8'h42;
                default: return 8'h00;
            endcase
        end
        return 8'(int'(code) * 13 + r * 37 + 5);
    endfunction

    function automatic logic [95:0] glyph_word(input logic [6:0] code);
        logic [95:0] w;
        w = '0;
        for (int r = 0; r < 12; r++) w[95 - 8*r -: 8] = glyph_line(code, r);
        return w;
    endfunction

    // Synchronous memories with one cycle of read latency.
    always @(posedge clock25) begin
        if (text_rd) text_data <= ram[text_addr];
        font_data <= glyph_word(font_addr);
    end

    function automatic logic [7:0] cell_byte(input int c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = pix[8*c + i];
        return b;
    endfunction

    // One clock with the counters at (v, h); outputs for h are sampled 1 ns after the edge.
    task automatic step(input int v, input int h);
        VerticalCounter   = 10'(v);
        HorizontalCounter = 10'(h);
        @(posedge clock25);
        #1;
        pix[h] = Pixel;
        pv[h]  = pixel_valid;
        if (text_rd === 1'b1) begin
            rd_count++;
            last_addr = text_addr;
        end
    endtask

    task automatic span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(v, h);
    endtask

    task automatic bump_frames(input int n);
        for (int i = 0; i < n; i++) step(480, 0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #5;
        checks++; if (Pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b expected 0", Pixel); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pixel_valid); end
        checks++; if (text_rd !== 1'b0) begin errors++; $display("FAIL reset_text_rd: got %b expected 0", text_rd); end
        checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL reset_text_addr: got %h expected 000", text_addr); end
        checks++; if (font_addr !== 7'd0) begin errors++; $display("FAIL reset_font_addr: got %h expected 00", font_addr); end
        step(0, 0);
        step(0, 0);
        reset_n = 1'b1;
        step(0, 0);
    endtask

    task automatic test_line0;
        int bad;
        int vcount;
        logic [7:0] pat;
        logic exp_bit;
        pat = 8'h18;
        rd_count = 0;
        span(524, 792, 799);
        checks++; if (rd_count !== 1) begin errors++; $display("FAIL wrap_fetch_count: got %0d expected 1", rd_count); end
        checks++; if (last_addr !== 12'd0) begin errors++; $display("FAIL wrap_fetch_addr: got %h expected 000", last_addr); end
        rd_count = 0;
        span(0, 0, 799);
        bad = 0;
        vcount = 0;
        for (int h = 0; h < 800; h++) begin
            exp_bit = (h < 640) ? pat[7 - (h % 8)] : 1'b0;
            if (pix[h] !== exp_bit) bad++;
            if (pv[h] === 1'b1) vcount++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL line0_pixels: got %0d wrong pixels expected 0", bad); end
        checks++; if (vcount !== 640) begin errors++; $display("FAIL line0_valid_count: got %0d expected 640", vcount); end
        checks++; if (rd_count !== 80) begin errors++; $display("FAIL line0_rd_count: got %0d expected 80", rd_count); end
        checks++; if (cell_byte(0) !== 8'b00011000) begin errors++; $display("FAIL line0_cell0: got %b expected 00011000", cell_byte(0)); end
        checks++; if (cell_byte(79) !== 8'b00011000) begin errors++; $display("FAIL line0_cell79: got %b expected 00011000", cell_byte(79)); end
    endtask

    task automatic test_inverse;
        ram[2*80 + 5] = 8'hC1;
        span(23, 792, 799);
        span(24, 0, 799);
        checks++; if (cell_byte(5) !== 8'b11100111) begin errors++; $display("FAIL inverse_cell5: got %b expected 11100111", cell_byte(5)); end
        checks++; if (cell_byte(4) !== 8'b00011000) begin errors++; $display("FAIL inverse_cell4: got %b expected 00011000", cell_byte(4)); end
        checks++; if (cell_byte(6) !== 8'b00011000) begin errors++; $display("FAIL inverse_cell6: got %b expected 00011000", cell_byte(6)); end
        ram[2*80 + 5] = 8'h41;
    endtask

    task automatic test_cursor;
        cursor_en  = 1'b1;
        cursor_col = 7'd0;
        cursor_row = 6'd0;
        span(9, 792, 799);
        span(10, 0, 15);
        checks++; if (cell_byte(0) !== 8'h81) begin errors++; $display("FAIL cursor_blink_off: got %h expected 81", cell_byte(0)); end
        bump_frames(32);
        span(9, 792, 799);
        span(10, 0, 15);
        checks++; if (cell_byte(0) !== 8'h7E) begin errors++; $display("FAIL cursor_line10: got %h expected 7e", cell_byte(0)); end
        checks++; if (cell_byte(1) !== 8'h81) begin errors++; $display("FAIL cursor_neighbour: got %h expected 81", cell_byte(1)); end
        span(10, 792, 799);
        span(11, 0, 15);
        checks++; if (cell_byte(0) !== 8'hBD) begin errors++; $display("FAIL cursor_line11: got %h expected bd", cell_byte(0)); end
        span(8, 792, 799);
        span(9, 0, 15);
        checks++; if (cell_byte(0) !== 8'h3C) begin errors++; $display("FAIL cursor_line9: got %h expected 3c", cell_byte(0)); end
        bump_frames(32);
        span(9, 792, 799);
        span(10, 0, 15);
        checks++; if (cell_byte(0) !== 8'h81) begin errors++; $display("FAIL cursor_wrap_off: got %h expected 81", cell_byte(0)); end
        cursor_en = 1'b0;
    endtask

    task automatic test_blank_line;
        int vcount;
        rd_count = 0;
        span(479, 624, 799);
        checks++; if (rd_count !== 1) begin errors++; $display("FAIL last_line_rd_count: got %0d expected 1", rd_count); end
        rd_count = 0;
        span(480, 0, 15);
        vcount = 0;
        for (int h = 0; h < 16; h++) if (pv[h] !== 1'b0 || pix[h] !== 1'b0) vcount++;
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL blank_line_rd_count: got %0d expected 0", rd_count); end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL blank_line_outputs: got %0d active samples expected 0", vcount); end
    endtask

    task automatic test_midframe_reset;
        int bad;
        logic [7:0] exp_b;
        for (int c = 0; c < 80; c++) ram[8*80 + c] = 8'(c + 32);
        span(99, 792, 799);
        span(100, 0, 299);
        exp_b = glyph_line(7'(10 + 32), 4);
        checks++; if (cell_byte(10) !== exp_b) begin errors++; $display("FAIL pre_reset_cell10: got %h expected %h", cell_byte(10), exp_b); end
        reset_n  = 1'b0;
        rd_count = 0;
        bad = 0;
        for (int h = 300; h < 310; h++) begin
            step(100, h);
            if (Pixel !== 1'b0 || pixel_valid !== 1'b0 || text_rd !== 1'b0
                || text_addr !== 12'd0 || font_addr !== 7'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL in_reset_outputs: got %0d nonzero samples expected 0", bad); end
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL in_reset_rd: got %0d expected 0", rd_count); end
        reset_n = 1'b1;
        span(100, 310, 799);
        checks++; if (cell_byte(38) !== 8'h00) begin errors++; $display("FAIL post_reset_cell38: got %h expected 00", cell_byte(38)); end
        checks++; if (cell_byte(39) !== 8'h00) begin errors++; $display("FAIL post_reset_cell39: got %h expected 00", cell_byte(39)); end
        span(101, 0, 799);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            exp_b = glyph_line(7'(c + 32), 5);
            if (cell_byte(c) !== exp_b) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL next_line_cells: got %0d wrong cells expected 0", bad); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rd_count   = 0;
        last_addr  = '0;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;
        text_data  = '0;
        font_data  = '0;
        HorizontalCounter = '0;
        VerticalCounter   = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h41;
        test_reset();
        test_line0();
        test_inverse();
        test_cursor();
        test_blank_line();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
